mips_multicycle: RTL and testbench
==================================

Name: mips_multicycle

Overview:
- Multicycle MIPS core with one shared memory port, for memories that need more than one cycle.
- The datapath holds internal state registers (IR, MDR, A, B, ALUOut) and is driven by an embedded controller FSM.
- Memory accesses use a req/ready handshake, so the core tolerates any number of wait states.
- It replaces the single-cycle core where instruction and data memory are unified.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RETIRE_CNT_W, 32, width of the retired-instruction counter; legal range 8..64.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mem_req  output  1  memory access request.
- mem_we  output  1  write strobe, qualified by mem_req.
- mem_addr  output  32  byte address.
- mem_wdata  output  32  store data.
- mem_rdata  input  32  load/fetch data, sampled when mem_req & mem_ready.
- mem_ready  input  1  access completes on the edge where mem_req & mem_ready.
- retire  output  1  one-cycle pulse when an instruction completes.
- retire_cnt  output  RETIRE_CNT_W  count of retired instructions; wraps to 0.
- illegal  output  1  sticky flag: an unsupported opcode or funct was decoded.

Behaviour:
- Reset values:
  - PC = RESET_PC; state = FETCH.
  - IR, MDR, A, B, ALUOut = 0.
  - retire = 0, retire_cnt = 0, illegal = 0.
  - mem_req and mem_we are forced 0 while reset is high.
  - Register-file contents are not reset.
- Supported instructions: lw, sw, beq, addi, j, and R-type add/sub/and/or/slt.
- alucontrol encoding: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- Register $0 reads 0; writes to $0 are discarded.
- All arithmetic is 32-bit modulo 2^32; overflow is ignored.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, addr=PC. Stays in FETCH until ready. On ready: IR<=rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(signext(imm)<<2). Go by opcode to MEMADR, EXECUTE, BRANCH, ADDIEX or JUMP. Unsupported opcode: set illegal, pulse retire, go to FETCH.
  - MEMADR: ALUOut<=A+signext(imm). Go to MEMRD (lw) or MEMWR (sw).
  - MEMRD: mem_req=1, addr=ALUOut. Stays until ready. On ready: MDR<=rdata, go to MEMWB.
  - MEMWB: rf[rt]<=MDR, retire, go to FETCH.
  - MEMWR: mem_req=1, mem_we=1, addr=ALUOut, wdata=B. Stays until ready. On ready: retire, go to FETCH.
  - EXECUTE: ALUOut<=A op B by funct; unsupported funct sets illegal. Go to ALUWB.
  - ALUWB: rf[rd]<=ALUOut (suppressed if funct is illegal), retire, go to FETCH.
  - ADDIEX: ALUOut<=A+signext(imm), go to ADDIWB.
  - ADDIWB: rf[rt]<=ALUOut, retire, go to FETCH.
  - BRANCH: if A==B then PC<=ALUOut. Retire, go to FETCH.
  - JUMP: PC<={PC[31:28], IR[25:0], 2'b00}. Retire, go to FETCH.
- Latency with mem_ready tied high:
  - beq and j: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds one cycle.
- Handshake rules:
  - While mem_req is high, mem_addr, mem_we and mem_wdata hold stable until ready.
  - mem_ready is ignored when mem_req=0.
  - In the non-memory states, mem_req=0 and mem_addr=PC.
- retire is high in the cycle the final state commits; retire_cnt increments on that same edge.
- Reset mid-access: the FSM returns to FETCH next edge and the pending access is abandoned. Memory must tolerate mem_req dropping without ready.
- mem_addr is not checked for alignment; the low two bits are passed through.

Optional Feature:
- Macro: MIPS_MC_BNE_EN.
- Defined: opcode 000101 (bne) is decoded to BRANCH. The branch is taken when A!=B; latency is 3 cycles.
- Not defined: bne is treated as an unsupported opcode (illegal set, no side effect, retired).

Decomposition:
- Package mips_mc_pkg holds:
  - FSM state enum.
  - Opcode constants: LW, SW, RTYPE, BEQ, ADDI, J, BNE.
  - Funct constants.
  - alucontrol encodings.
- Sub-module mips_mc_ctrl: FSM, decode, and mux/enable generation.
- The datapath reuses the existing flopr, mux2, regfile, signext, sl2 and alu blocks.

Test Plan:
- Reset with RESET_PC=32'h100, mem_ready=1 -> the first request has mem_addr=0x100 and mem_we=0; retire_cnt=0.
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> rf[3]=12; retire_cnt=3 after 12 cycles.
- sw $3,8($0) with mem_ready low for 3 cycles -> addr=8 and wdata=12 held stable for 4 cycles; then one retire.
- lw $4,8($0) -> rf[4]=12; beq $4,$3,-2 -> next fetch is at PC+4-8.
- j 0x40 at PC 0x1000_0010 -> next fetch at 0x1000_0100.
- Opcode 111111 -> illegal=1, no register or memory write, retire pulses.
- With MIPS_MC_BNE_EN defined: bne $1,$2 taken when 5!=7.
- Assert reset during a MEMRD wait -> the next cycle is FETCH at RESET_PC.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared types for the multicycle MIPS core: FSM states, opcode/funct codes, ALU control.
// Pure declarations; no timing or backpressure of its own.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_e;

  typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMMSL2} srcb_e;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP} pcsrc_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic funct_valid(input logic [5:0] f);
    return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// Controller FSM: one state per cycle, memory states hold until mem_ready; bne via MIPS_MC_BNE_EN.
// Control lines are decoded from the registered state; mem_req/mem_we/retire are forced low in reset.
module mips_mc_ctrl
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output pcsrc_e     pc_src_o,
  output logic       alu_srca_o,
  output srcb_e      alu_srcb_o,
  output logic [2:0] alu_ctl_o,
  output logic       aluout_we_o,
  output logic       ab_we_o,
  output logic       mdr_we_o,
  output logic       rf_we_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       retire_o,
  output logic       illegal_o
);

  state_e state_q, state_d;
  logic   illegal_q;
  logic   is_bne, op_ok, funct_ok;

`ifdef MIPS_MC_BNE_EN
  assign is_bne = (op_i == OP_BNE);
`else
  assign is_bne = 1'b0;
`endif

  assign op_ok     = (op_i inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J}) || is_bne;
  assign funct_ok  = funct_valid(funct_i);
  assign illegal_o = illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_DECODE && !op_ok) || (state_q == S_EXECUTE && !funct_ok))
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = PC_ALU;
    alu_srca_o   = 1'b0;
    alu_srcb_o   = SRCB_B;
    alu_ctl_o    = ALU_ADD;
    aluout_we_o  = 1'b0;
    ab_we_o      = 1'b0;
    mdr_we_o     = 1'b0;
    rf_we_o      = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    retire_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o  = 1'b1;
        alu_srcb_o = SRCB_FOUR;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // PC already points past this instruction, so ALUOut gets the branch target
        ab_we_o     = 1'b1;
        alu_srcb_o  = SRCB_IMMSL2;
        aluout_we_o = 1'b1;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d  = is_bne ? S_BRANCH : S_FETCH;
            retire_o = !is_bne;
          end
        endcase
      end
      S_MEMADR: begin
        alu_srca_o  = 1'b1;
        alu_srcb_o  = SRCB_IMM;
        aluout_we_o = 1'b1;
        state_d     = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          mdr_we_o = 1'b1;
          state_d  = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we_o      = 1'b1;
        mem_to_reg_o = 1'b1;
        retire_o     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          retire_o = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_srca_o  = 1'b1;
        alu_ctl_o   = funct_alu(funct_i);
        aluout_we_o = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we_o   = funct_ok;
        reg_dst_o = 1'b1;
        retire_o  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_srca_o  = 1'b1;
        alu_srcb_o  = SRCB_IMM;
        aluout_we_o = 1'b1;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we_o  = 1'b1;
        retire_o = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alu_srca_o = 1'b1;
        alu_ctl_o  = ALU_SUB;
        pc_src_o   = PC_ALUOUT;
        pc_we_o    = is_bne ? !zero_i : zero_i;
        retire_o   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src_o = PC_JUMP;
        pc_we_o  = 1'b1;
        retire_o = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      rf_we_o   = 1'b0;
      retire_o  = 1'b0;
    end
  end

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core on one shared req/ready memory port; bne optional via MIPS_MC_BNE_EN.
// 3 (beq/j), 4 (R/addi/sw) or 5 (lw) cycles plus one per memory wait cycle; request held until ready.
module mips_multicycle
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready,
  output logic                    retire,
  output logic [RETIRE_CNT_W-1:0] retire_cnt,
  output logic                    illegal
);

  localparam logic [RETIRE_CNT_W-1:0] CNT_ONE = {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
  logic [RETIRE_CNT_W-1:0] cnt_q;
  logic [31:0] rf_q [32];

  logic        iord, ir_we, pc_we, alu_srca, aluout_we, ab_we, mdr_we;
  logic        rf_we, reg_dst, mem_to_reg, zero;
  pcsrc_e      pc_src;
  srcb_e       alu_srcb;
  logic [2:0]  alu_ctl;
  logic [31:0] imm_ext, src_a, src_b, alu_y, pc_d, rd1, rd2, wd;
  logic [4:0]  wa;

  mips_mc_ctrl u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .op_i         (ir_q[31:26]),
    .funct_i      (ir_q[5:0]),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .iord_o       (iord),
    .ir_we_o      (ir_we),
    .pc_we_o      (pc_we),
    .pc_src_o     (pc_src),
    .alu_srca_o   (alu_srca),
    .alu_srcb_o   (alu_srcb),
    .alu_ctl_o    (alu_ctl),
    .aluout_we_o  (aluout_we),
    .ab_we_o      (ab_we),
    .mdr_we_o     (mdr_we),
    .rf_we_o      (rf_we),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .retire_o     (retire),
    .illegal_o    (illegal)
  );

  assign imm_ext    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rd1        = (ir_q[25:21] == 5'd0) ? '0 : rf_q[ir_q[25:21]];
  assign rd2        = (ir_q[20:16] == 5'd0) ? '0 : rf_q[ir_q[20:16]];
  assign wa         = reg_dst ? ir_q[15:11] : ir_q[20:16];
  assign wd         = mem_to_reg ? mdr_q : aluout_q;
  assign src_a      = alu_srca ? a_q : pc_q;
  assign zero       = (alu_y == 32'd0);
  assign mem_addr   = iord ? aluout_q : pc_q;
  assign mem_wdata  = b_q;
  assign retire_cnt = cnt_q;

  always_comb begin
    case (alu_srcb)
      SRCB_FOUR:   src_b = 32'd4;
      SRCB_IMM:    src_b = imm_ext;
      SRCB_IMMSL2: src_b = {imm_ext[29:0], 2'b00};
      default:     src_b = b_q;
    endcase
  end

  always_comb begin
    case (alu_ctl)
      ALU_ADD: alu_y = src_a + src_b;
      ALU_SUB: alu_y = src_a - src_b;
      ALU_AND: alu_y = src_a & src_b;
      ALU_OR:  alu_y = src_a | src_b;
      ALU_SLT: alu_y = {31'b0, $signed(src_a) < $signed(src_b)};
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    case (pc_src)
      PC_ALUOUT: pc_d = aluout_q;
      PC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default:   pc_d = alu_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (pc_we)     pc_q     <= pc_d;
      if (ir_we)     ir_q     <= mem_rdata;
      if (mdr_we)    mdr_q    <= mem_rdata;
      if (aluout_we) aluout_q <= alu_y;
      if (ab_we) begin
        a_q <= rd1;
        b_q <= rd2;
      end
      if (retire)    cnt_q    <= cnt_q + CNT_ONE;
    end
  end

  // Register file is deliberately not reset; $0 is handled on the read side.
  always_ff @(posedge clk) begin
    if (rf_we && wa != 5'd0) rf_q[wa] <= wd;
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench: a short program in a word memory with controllable ready, plus a second core
// that only ever fetches a jump, for the upper-PC-bits jump case.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, retire, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, retire_cnt;
  logic        req2, we2, ready2, retire2, illegal2;
  logic [31:0] addr2, wdata2, rdata2, cnt2;
  logic        patch;
  logic [31:0] mem_words [0:255];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_multicycle #(.RESET_PC(32'h0000_0100), .RETIRE_CNT_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .retire_cnt(retire_cnt), .illegal(illegal)
  );

  mips_multicycle #(.RESET_PC(32'h1000_0010), .RETIRE_CNT_W(32)) dut_j (
    .clk(clk), .reset(reset), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ready(ready2),
    .retire(retire2), .retire_cnt(cnt2), .illegal(illegal2)
  );

  assign rdata2    = 32'h0800_0040;
  assign ready2    = 1'b1;
  assign mem_rdata = mem_words[mem_addr[9:2]];

  always @(posedge clk) begin
    if (reset) begin
      mem_words[8'h02] <= 32'hDEAD_BEEF;
      mem_words[8'h40] <= 32'h2001_0005;  // addi $1,$0,5
      mem_words[8'h41] <= 32'h2002_0007;  // addi $2,$0,7
      mem_words[8'h42] <= 32'h0022_1820;  // add  $3,$1,$2
      mem_words[8'h43] <= 32'hAC03_0008;  // sw   $3,8($0)
      mem_words[8'h44] <= 32'h8C04_0008;  // lw   $4,8($0)
      mem_words[8'h45] <= 32'h1083_FFFE;  // beq  $4,$3,-2
      mem_words[8'h46] <= 32'h8C05_0008;  // lw   $5,8($0)
      mem_words[8'h48] <= 32'h8C05_0008;  // lw   $5,8($0)
    end else if (patch) begin
      mem_words[8'h44] <= 32'hFC00_0000;  // opcode 111111
      mem_words[8'h45] <= 32'h1422_0002;  // bne  $1,$2,+2
    end else if (mem_req && mem_we && mem_ready) begin
      mem_words[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    patch     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    #1;
    // cycle 1: first fetch
    check("fetch0_req", 32'(mem_req), 32'd1);
    check("fetch0_we", 32'(mem_we), 32'd0);
    check("fetch0_addr", mem_addr, 32'h0000_0100);
    check("j_fetch0_addr", addr2, 32'h1000_0010);
    tick(2);  // cycle 3
    check("j_retire", 32'(retire2), 32'd1);
    check("j_noreq", 32'(req2), 32'd0);
    tick(1);  // cycle 4
    check("j_target", addr2, 32'h1000_0100);
    check("j_cnt", cnt2, 32'd1);
    tick(8);  // cycle 12: add writes back
    check("add_retire", 32'(retire), 32'd1);
    check("add_cnt_before", retire_cnt, 32'd2);
    tick(1);  // cycle 13
    check("cnt_after_12", retire_cnt, 32'd3);
    check("sw_fetch_addr", mem_addr, 32'h0000_010C);
    tick(3);  // cycle 16: MEMWR with wait states
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("sw_req", 32'(mem_req), 32'd1);
      check("sw_we", 32'(mem_we), 32'd1);
      check("sw_addr", mem_addr, 32'h0000_0008);
      check("sw_wdata", mem_wdata, 32'd12);
      check("sw_noretire", 32'(retire), 32'd0);
      tick(1);
    end
    mem_ready = 1'b1;  // cycle 19
    #1;
    check("sw_addr_last", mem_addr, 32'h0000_0008);
    check("sw_wdata_last", mem_wdata, 32'd12);
    check("sw_retire", 32'(retire), 32'd1);
    tick(1);  // cycle 20
    check("sw_mem", mem_words[2], 32'd12);
    check("sw_cnt", retire_cnt, 32'd4);
    check("lw_fetch_addr", mem_addr, 32'h0000_0110);
    tick(3);  // cycle 23: MEMRD
    check("lw_req", 32'(mem_req), 32'd1);
    check("lw_we", 32'(mem_we), 32'd0);
    check("lw_addr", mem_addr, 32'h0000_0008);
    tick(1);  // cycle 24: MEMWB
    check("lw_retire", 32'(retire), 32'd1);
    check("lw_wb_addr", mem_addr, 32'h0000_0114);
    tick(1);  // cycle 25: fetch beq
    check("lw_cnt", retire_cnt, 32'd5);
    tick(1);  // cycle 26
    patch = 1'b1;
    tick(1);  // cycle 27: BRANCH
    patch = 1'b0;
    check("beq_retire", 32'(retire), 32'd1);
    tick(1);  // cycle 28
    check("beq_target", mem_addr, 32'h0000_0110);
    check("beq_cnt", retire_cnt, 32'd6);
    tick(1);  // cycle 29: DECODE of opcode 111111
    check("ill_retire", 32'(retire), 32'd1);
    check("ill_noreq", 32'(mem_req), 32'd0);
    tick(1);  // cycle 30
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_next_pc", mem_addr, 32'h0000_0114);
    check("ill_cnt", retire_cnt, 32'd7);
    check("ill_nomemwr", mem_words[2], 32'd12);
    tick(1);  // cycle 31: DECODE of bne
`ifdef MIPS_MC_BNE_EN
    check("bne_decode_noretire", 32'(retire), 32'd0);
    tick(1);
    check("bne_retire", 32'(retire), 32'd1);
    tick(1);
    check("bne_taken", mem_addr, 32'h0000_0120);
`else
    check("bne_ill_retire", 32'(retire), 32'd1);
    tick(1);
    check("bne_ill_pc", mem_addr, 32'h0000_0118);
`endif
    check("bne_cnt", retire_cnt, 32'd8);
    tick(3);  // MEMRD of lw $5
    mem_ready = 1'b0;
    #1;
    check("rstrd_req", 32'(mem_req), 32'd1);
    check("rstrd_addr", mem_addr, 32'h0000_0008);
    tick(1);
    check("rstrd_hold", mem_addr, 32'h0000_0008);
    reset = 1'b1;
    #1;
    check("rstrd_forced_req", 32'(mem_req), 32'd0);
    tick(1);
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rstrd_fetch_req", 32'(mem_req), 32'd1);
    check("rstrd_fetch_we", 32'(mem_we), 32'd0);
    check("rstrd_fetch_addr", mem_addr, 32'h0000_0100);
    check("rstrd_cnt", retire_cnt, 32'd0);
    check("rstrd_illegal", 32'(illegal), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
